// File: rtl/rs_pkg.sv
// Shared constants, GF(8) constant-multiply helpers and FSM encoding for the RS(7,5) correction path.
package rs_pkg;

    localparam int N            = 7;
    localparam int K            = 5;
    localparam int SYMBOL_WIDTH = 3;
    localparam int CW_WIDTH     = N * SYMBOL_WIDTH;

    // x^3 + x + 1
    localparam logic [SYMBOL_WIDTH:0] PRIM_POLY = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    function automatic logic [SYMBOL_WIDTH-1:0] gf8_mul_alpha(input logic [SYMBOL_WIDTH-1:0] x);
        logic [SYMBOL_WIDTH:0] shifted;
        shifted = {x, 1'b0};
        if (shifted[SYMBOL_WIDTH])
            shifted = shifted ^ PRIM_POLY;
        return shifted[SYMBOL_WIDTH-1:0];
    endfunction

    // Undo one alpha step: an odd value means the reduction polynomial was folded in.
    function automatic logic [SYMBOL_WIDTH-1:0] gf8_mul_alpha_inv(input logic [SYMBOL_WIDTH-1:0] x);
        logic [SYMBOL_WIDTH:0] unshifted;
        unshifted = {1'b0, x};
        if (x[0])
            unshifted = unshifted ^ PRIM_POLY;
        return unshifted[SYMBOL_WIDTH:1];
    endfunction

endpackage

// File: rtl/gf8_const_step.sv
// One search step of the locator walk: X advances by alpha, E retreats by alpha^-1.
module gf8_const_step
    import rs_pkg::*;
(
    input  logic [SYMBOL_WIDTH-1:0] x,
    input  logic [SYMBOL_WIDTH-1:0] e,
    output logic [SYMBOL_WIDTH-1:0] x_alpha,
    output logic [SYMBOL_WIDTH-1:0] e_alpha_inv
);

    assign x_alpha     = gf8_mul_alpha(x);
    assign e_alpha_inv = gf8_mul_alpha_inv(e);

endmodule

// File: rtl/rs75_error_corrector.sv
// RS(7,5) single-symbol corrector: walks S1*alpha^j until it equals S2, then flips symbol j by S1*alpha^-j.
module rs75_error_corrector
    import rs_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CW_WIDTH-1:0]     in_word,
    input  logic [SYMBOL_WIDTH-1:0] in_s1,
    input  logic [SYMBOL_WIDTH-1:0] in_s2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CW_WIDTH-1:0]     out_word,
    output logic                    out_corrected,
    output logic [2:0]              out_err_pos,
    output logic                    out_uncorrectable
);

    localparam logic [2:0] LAST_POS = 3'(N - 1);

    state_t                  state_reg, state_next;
    logic [CW_WIDTH-1:0]     word_reg;
    logic [CW_WIDTH-1:0]     corr_mask;
    logic [SYMBOL_WIDTH-1:0] s2_reg, x_reg, e_reg;
    logic [SYMBOL_WIDTH-1:0] x_step, e_step;
    logic [2:0]              j_reg, err_pos_reg;
    logic                    corrected_reg, uncorrectable_reg;
    logic                    match;

    gf8_const_step u_step (
        .x           (x_reg),
        .e           (e_reg),
        .x_alpha     (x_step),
        .e_alpha_inv (e_step)
    );

    assign match = (x_reg == s2_reg);

    // Place the error magnitude on the symbol currently under test.
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign corr_mask[gi*SYMBOL_WIDTH +: SYMBOL_WIDTH] =
            (j_reg == 3'(gi)) ? e_reg : '0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    if (in_s1 == '0 || in_s2 == '0)
                        state_next = ST_OUT;
                    else
                        state_next = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (match || j_reg == LAST_POS)
                    state_next = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == ST_IDLE);
        out_valid = (state_reg == ST_OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_reg          <= '0;
            s2_reg            <= '0;
            x_reg             <= '0;
            e_reg             <= '0;
            j_reg             <= '0;
            err_pos_reg       <= '0;
            corrected_reg     <= 1'b0;
            uncorrectable_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        word_reg          <= in_word;
                        s2_reg            <= in_s2;
                        x_reg             <= in_s1;
                        e_reg             <= in_s1;
                        j_reg             <= '0;
                        err_pos_reg       <= '0;
                        corrected_reg     <= 1'b0;
                        uncorrectable_reg <= (in_s1 == '0) != (in_s2 == '0);
                    end
                end
                ST_SEARCH: begin
                    if (match) begin
                        word_reg      <= word_reg ^ corr_mask;
                        corrected_reg <= 1'b1;
                        err_pos_reg   <= j_reg;
                    end else if (j_reg == LAST_POS) begin
                        // Unreachable with two nonzero syndromes; kept as a safe exit.
                        uncorrectable_reg <= 1'b1;
                    end else begin
                        x_reg <= x_step;
                        e_reg <= e_step;
                        j_reg <= j_reg + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_word          = word_reg;
    assign out_corrected     = corrected_reg;
    assign out_err_pos       = err_pos_reg;
    assign out_uncorrectable = uncorrectable_reg;

endmodule

// File: tb/tb_rs75_error_corrector.sv
// Directed-vector bench for rs75_error_corrector: latency, correction, flags, backpressure and reset.
module tb_rs75_error_corrector;
    import rs_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [CW_WIDTH-1:0]     in_word;
    logic [SYMBOL_WIDTH-1:0] in_s1, in_s2;
    logic                    out_valid;
    logic                    out_ready;
    logic [CW_WIDTH-1:0]     out_word;
    logic                    out_corrected;
    logic [2:0]              out_err_pos;
    logic                    out_uncorrectable;

    int n_vectors     = 0;
    int n_miscompares = 0;

    rs75_error_corrector dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_word           (in_word),
        .in_s1             (in_s1),
        .in_s2             (in_s2),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_word          (out_word),
        .out_corrected     (out_corrected),
        .out_err_pos       (out_err_pos),
        .out_uncorrectable (out_uncorrectable)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vectors++;
        if (observed !== expected) begin
            n_miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Apply one word, measure latency, check results, optionally hold off out_ready, then handshake.
    task automatic run_vector(input string name,
                              input logic [CW_WIDTH-1:0] word,
                              input logic [2:0] s1, input logic [2:0] s2,
                              input logic [CW_WIDTH-1:0] exp_word,
                              input logic exp_corr, input logic [2:0] exp_pos,
                              input logic exp_unc, input int exp_lat, input int hold);
        int lat;
        in_word  = word;
        in_s1    = s1;
        in_s2    = s2;
        in_valid = 1'b1;
        check_value({name, ".in_ready_before"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        lat = 1;
        #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check_value({name, ".latency"}, 32'(lat), 32'(exp_lat));
        check_value({name, ".word"}, 32'(out_word), 32'(exp_word));
        check_value({name, ".corrected"}, 32'(out_corrected), 32'(exp_corr));
        check_value({name, ".err_pos"}, 32'(out_err_pos), 32'(exp_pos));
        check_value({name, ".uncorrectable"}, 32'(out_uncorrectable), 32'(exp_unc));
        check_value({name, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            check_value({name, ".hold_valid"}, 32'(out_valid), 32'd1);
            check_value({name, ".hold_word"}, 32'(out_word), 32'(exp_word));
            check_value({name, ".hold_corr"}, 32'(out_corrected), 32'(exp_corr));
            check_value({name, ".hold_pos"}, 32'(out_err_pos), 32'(exp_pos));
            check_value({name, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_value({name, ".post_valid"}, 32'(out_valid), 32'd0);
        check_value({name, ".post_in_ready"}, 32'(in_ready), 32'd1);
        $display("vector %s: lat=%0d word=%o corr=%0b pos=%0d unc=%0b",
                 name, lat, out_word, out_corrected, out_err_pos, out_uncorrectable);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_word   = '0;
        in_s1     = '0;
        in_s2     = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("reset.in_ready", 32'(in_ready), 32'd1);
        check_value("reset.out_valid", 32'(out_valid), 32'd0);
        check_value("reset.out_word", 32'(out_word), 32'd0);
        check_value("reset.corrected", 32'(out_corrected), 32'd0);
        check_value("reset.err_pos", 32'(out_err_pos), 32'd0);
        check_value("reset.uncorrectable", 32'(out_uncorrectable), 32'd0);
        rst = 1'b0;

        //          name         word          s1    s2    exp_word      corr  pos   unc  lat hold
        run_vector("no_error",  21'o0000000, 3'd0, 3'd0, 21'o0000000, 1'b0, 3'd0, 1'b0, 1, 0);
        run_vector("pos0",      21'o1234567, 3'd1, 3'd1, 21'o1234566, 1'b1, 3'd0, 1'b0, 2, 0);
        run_vector("pos2",      21'o0000000, 3'd7, 3'd1, 21'o0000300, 1'b1, 3'd2, 1'b0, 4, 0);
        run_vector("pos3",      21'o1111111, 3'd1, 3'd3, 21'o1117111, 1'b1, 3'd3, 1'b0, 5, 0);
        run_vector("pos6",      21'o7654321, 3'd1, 3'd5, 21'o5654321, 1'b1, 3'd6, 1'b0, 8, 0);
        run_vector("unc_s2z",   21'o0123456, 3'd3, 3'd0, 21'o0123456, 1'b0, 3'd0, 1'b1, 1, 0);
        run_vector("unc_s1z",   21'o6543210, 3'd0, 3'd4, 21'o6543210, 1'b0, 3'd0, 1'b1, 1, 0);
        run_vector("backpress", 21'o0000000, 3'd7, 3'd1, 21'o0000300, 1'b1, 3'd2, 1'b0, 4, 5);

        // Reset mid-search discards the word.
        in_word  = 21'o7654321;
        in_s1    = 3'd1;
        in_s2    = 3'd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("search.in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_value("rst_search.in_ready", 32'(in_ready), 32'd1);
        check_value("rst_search.out_valid", 32'(out_valid), 32'd0);
        check_value("rst_search.out_word", 32'(out_word), 32'd0);
        check_value("rst_search.corrected", 32'(out_corrected), 32'd0);
        $display("vector rst_search: in_ready=%0b out_valid=%0b", in_ready, out_valid);

        run_vector("recover",   21'o0000000, 3'd1, 3'd1, 21'o0000001, 1'b1, 3'd0, 1'b0, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
